eth_rx_axis_frame_fifo: RTL and testbench

- Sits behind the RX MAC and turns its valid-only output stream (i_data*, no backpressure) into an AXI-Stream master with full tready backpressure.
- Store-and-forward packet FIFO. Only complete, error-free frames that fit in the buffer are released downstream.
- Frames flagged bad by the MAC, or frames that overflow the buffer, are rolled back and never appear on m_axis.
- Single clock domain: the RX MAC clock.

---
 rtl/eth_rx_axis_frame_fifo.sv | 230 +++++++++++++++++++++++
 tb/tb_eth_rx_axis_frame_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_axis_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_axis_frame_fifo
// Purpose  : Store-and-forward RX frame FIFO. Accepts the valid-only RX MAC
//            beat stream and releases only complete, error-free frames that
//            fit in the buffer on an AXI-Stream master with tready
//            backpressure. Bad or overflowing frames are rolled back.
// Ports    : i_rx_clk / i_rx_reset_n    clock, async active-low reset
//            i_data* (data/keep/last/valid/err)  RX MAC beat stream
//            m_axis_t* / m_axis_trdy     AXI-Stream master, registered
//            o_frame_dropped            1-cycle pulse per discarded frame
//            o_overflow                 1-cycle pulse on first lost beat
//            o_good_frames/o_bad_frames saturating frame counters, present
//                                       only with ETH_RX_FIFO_STATS_EN
// Options  : `define ETH_RX_FIFO_STATS_EN to add the frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_axis_frame_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_rx_clk,
  input  logic                  i_rx_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_data_keep,
  input  logic                  i_data_last,
  input  logic                  i_data_valid,
  input  logic                  i_data_err,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CTRL_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_trdy,
  output logic                  o_frame_dropped,
  output logic                  o_overflow
`ifdef ETH_RX_FIFO_STATS_EN
  ,
  output logic [31:0]           o_good_frames,
  output logic [31:0]           o_bad_frames
`endif
);

  localparam int ENTRY_W = DATA_WIDTH + CTRL_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   FULL_LVL = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  // Entry layout: {tlast, tkeep, tdata}
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  wr_state_e           state_q;
  logic [ADDR_WIDTH:0] wr_cur_q, wr_cur_d;
  logic [ADDR_WIDTH:0] wr_com_q;
  logic [ADDR_WIDTH:0] com_ptr_q;
  logic                commit_pend_q;
  logic [ADDR_WIDTH:0] rd_ptr_q;
  logic                dropped_q;
  logic                overflow_q;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic [CTRL_WIDTH-1:0] tkeep_q;
  logic                  tlast_q;
  logic                  tvalid_q;

  // ---------------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------------
  logic                  beat_acc;
  logic                  in_drop;
  logic [ADDR_WIDTH:0]   used;
  logic                  full;
  logic                  ovf;
  logic                  wr_en;
  logic                  last_beat;
  logic                  empty_last;
  logic                  rollback;
  logic                  commit;
  logic                  mark_prev;
  logic [ADDR_WIDTH:0]   com_eff;
  logic [ADDR_WIDTH-1:0] prev_idx;

  assign beat_acc  = i_data_valid && (|i_data_keep);
  assign in_drop   = (state_q == ST_DROP);
  // One slot is always left empty, so a frame can hold at most DEPTH-1 words.
  assign used      = wr_cur_q - rd_ptr_q;
  assign full      = (used == FULL_LVL);
  assign ovf       = beat_acc && full && !in_drop;
  assign wr_en     = beat_acc && !full && !in_drop;
  assign last_beat = i_data_valid && i_data_last;
  // A keep==0 last beat with nothing stored yet carries no frame at all.
  assign empty_last = last_beat && !(|i_data_keep) && (state_q == ST_IDLE);
  assign rollback  = last_beat && (in_drop || ovf || i_data_err || empty_last);
  assign commit    = last_beat && !rollback;
  assign mark_prev = commit && !(|i_data_keep);
  // The previous frame may still be waiting for its commit to land in
  // wr_com_q; a rollback must not fall behind it.
  assign com_eff   = commit_pend_q ? com_ptr_q : wr_com_q;
  assign prev_idx  = wr_cur_q[ADDR_WIDTH-1:0] - IDX_ONE;

  always_comb begin
    wr_cur_d = wr_cur_q;
    if (rollback) begin
      wr_cur_d = com_eff;
    end else if (wr_en) begin
      wr_cur_d = wr_cur_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_rx_clk) begin
    if (wr_en) begin
      mem_q[wr_cur_q[ADDR_WIDTH-1:0]] <= {i_data_last, i_data_keep, i_data};
    end
    if (mark_prev) begin
      mem_q[prev_idx][ENTRY_W-1] <= 1'b1;
    end
  end

  // Write-side state machine and pointer bookkeeping
  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      state_q       <= ST_IDLE;
      wr_cur_q      <= '0;
      wr_com_q      <= '0;
      com_ptr_q     <= '0;
      commit_pend_q <= 1'b0;
      dropped_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_cur_q      <= wr_cur_d;
      dropped_q     <= rollback;
      overflow_q    <= ovf;
      commit_pend_q <= commit;
      // Commit lands one edge after the last beat.
      if (commit_pend_q) begin
        wr_com_q <= com_ptr_q;
      end
      if (commit) begin
        com_ptr_q <= wr_cur_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (wr_en && !i_data_last) begin
            state_q <= ST_FRAME;
          end else if (ovf && !i_data_last) begin
            state_q <= ST_DROP;
          end
        end
        ST_FRAME: begin
          if (last_beat) begin
            state_q <= ST_IDLE;
          end else if (ovf) begin
            state_q <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (last_beat) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: single registered output stage
  // ---------------------------------------------------------------------------
  logic               avail;
  logic               load;
  logic [ENTRY_W-1:0] rd_entry;

  assign avail    = (rd_ptr_q != wr_com_q);
  assign load     = avail && (!tvalid_q || m_axis_trdy);
  assign rd_entry = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      rd_ptr_q <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (load) begin
      rd_ptr_q <= rd_ptr_q + PTR_ONE;
      {tlast_q, tkeep_q, tdata_q} <= rd_entry;
      tvalid_q <= 1'b1;
    end else if (m_axis_trdy) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tkeep    = tkeep_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tvalid   = tvalid_q;
  assign o_frame_dropped = dropped_q;
  assign o_overflow      = overflow_q;

`ifdef ETH_RX_FIFO_STATS_EN
  logic [31:0] good_q;
  logic [31:0] bad_q;

  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (commit_pend_q && (good_q != 32'hFFFF_FFFF)) begin
        good_q <= good_q + 32'd1;
      end
      if (dropped_q && (bad_q != 32'hFFFF_FFFF)) begin
        bad_q <= bad_q + 32'd1;
      end
    end
  end

  assign o_good_frames = good_q;
  assign o_bad_frames  = bad_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_axis_frame_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_eth_rx_axis_frame_fifo
// Purpose  : Self-checking bench. Instance 0 uses the default DEPTH, instance
//            1 uses DEPTH=16 for the overflow scenario. A queue-level frame
//            model predicts outputs every cycle; directed literal checks pin
//            latency, beat counts, tlast/tkeep placement and pulse counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_axis_frame_fifo;

  typedef logic [36:0] ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        last, err, vld, sel;
  logic [1:0]  trdy;
  logic [1:0]  vin;

  logic [1:0][31:0] tdata;
  logic [1:0][3:0]  tkeep;
  logic [1:0]       tvalid, tlast, dropped, ovfl;

  always #5 clk = ~clk;
  assign vin = {vld & sel, vld & ~sel};

  eth_rx_axis_frame_fifo dut0 (
    .i_rx_clk(clk), .i_rx_reset_n(rst_n), .i_data(data), .i_data_keep(keep),
    .i_data_last(last), .i_data_valid(vin[0]), .i_data_err(err),
    .m_axis_tdata(tdata[0]), .m_axis_tkeep(tkeep[0]), .m_axis_tvalid(tvalid[0]),
    .m_axis_tlast(tlast[0]), .m_axis_trdy(trdy[0]),
    .o_frame_dropped(dropped[0]), .o_overflow(ovfl[0]));

  eth_rx_axis_frame_fifo #(.DEPTH(16)) dut1 (
    .i_rx_clk(clk), .i_rx_reset_n(rst_n), .i_data(data), .i_data_keep(keep),
    .i_data_last(last), .i_data_valid(vin[1]), .i_data_err(err),
    .m_axis_tdata(tdata[1]), .m_axis_tkeep(tkeep[1]), .m_axis_tvalid(tvalid[1]),
    .m_axis_tlast(tlast[1]), .m_axis_trdy(trdy[1]),
    .o_frame_dropped(dropped[1]), .o_overflow(ovfl[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame model: committed words form a list (head..tot), words become
  // readable one cycle after commit (vis), the open frame is kept aside.
  // ---------------------------------------------------------------------------
  ent_t L  [2][0:4095];
  ent_t cf [2][0:63];
  int   head[2], vis[2], tot[2], cfn[2], dep[2];
  bit   dropping[2];
  bit   mov[2], mdrop[2], movf[2];
  ent_t moe[2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      head[k] = 0; vis[k] = 0; tot[k] = 0; cfn[k] = 0;
      dropping[k] = 0; mov[k] = 0; mdrop[k] = 0; movf[k] = 0; moe[k] = '0;
    end
    dep[0] = 512; dep[1] = 16;
  endtask

  task automatic mcommit(input int k);
    for (int i = 0; i < cfn[k]; i++) L[k][tot[k]+i] = cf[k][i];
    tot[k] += cfn[k];
    cfn[k] = 0;
  endtask

  task automatic mstep(input int k, input bit v, input bit tr);
    bit full;
    full = ((tot[k] - head[k] + cfn[k]) == dep[k] - 1);
    if (!mov[k] || tr) begin
      if (head[k] < vis[k]) begin
        moe[k] = L[k][head[k]]; head[k]++; mov[k] = 1;
      end else begin
        mov[k] = 0;
      end
    end
    vis[k] = tot[k];
    mdrop[k] = 0; movf[k] = 0;
    if (v) begin
      if (dropping[k]) begin
        if (last) begin dropping[k] = 0; mdrop[k] = 1; end
      end else if (keep != 0) begin
        if (full) begin
          movf[k] = 1; cfn[k] = 0;
          if (last) mdrop[k] = 1; else dropping[k] = 1;
        end else begin
          cf[k][cfn[k]] = {last, keep, data}; cfn[k]++;
          if (last) begin
            if (err) begin mdrop[k] = 1; cfn[k] = 0; end
            else mcommit(k);
          end
        end
      end else if (last) begin
        if (cfn[k] == 0 || err) begin mdrop[k] = 1; cfn[k] = 0; end
        else begin cf[k][cfn[k]-1][36] = 1'b1; mcommit(k); end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else begin
      mstep(0, vin[0], trdy[0]);
      mstep(1, vin[1], trdy[1]);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("tvalid", k, 64'(tvalid[k]), 64'(mov[k]));
      if (mov[k]) begin
        chk("tdata", k, 64'(tdata[k]), 64'(moe[k][31:0]));
        chk("tkeep", k, 64'(tkeep[k]), 64'(moe[k][35:32]));
        chk("tlast", k, 64'(tlast[k]), 64'(moe[k][36]));
      end
      chk("dropped", k, 64'(dropped[k]), 64'(mdrop[k]));
      chk("overflow", k, 64'(ovfl[k]), 64'(movf[k]));
    end
  end

  // Observation log for the directed literal checks
  ent_t obs_e [2][0:255];
  int   obs_c [2][0:255];
  int   obs_n[2], drop_n[2], drop_c[2], ov_n[2], ov_beat[2], inb[2], lastc[2];
  int   cyc = 0;

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      obs_n[k] = 0; drop_n[k] = 0; drop_c[k] = 0; ov_n[k] = 0;
      ov_beat[k] = 0; inb[k] = 0; lastc[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tvalid[k] && trdy[k]) begin
        obs_e[k][obs_n[k]] = {tlast[k], tkeep[k], tdata[k]};
        obs_c[k][obs_n[k]] = cyc;
        obs_n[k]++;
      end
      if (dropped[k]) begin drop_n[k]++; drop_c[k] = cyc; end
      if (ovfl[k]) begin ov_n[k]++; ov_beat[k] = inb[k]; end
      if (vin[k]) begin
        inb[k]++;
        if (last) lastc[k] = cyc;
      end
    end
    cyc++;
  end

  task automatic drive(input bit k, input logic [31:0] d, input logic [3:0] kp, input bit l, input bit e);
    @(negedge clk);
    sel = k; data = d; keep = kp; last = l; err = e; vld = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0; last = 1'b0; err = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; sel = 1'b0; data = '0; keep = '0;
    last = 1'b0; err = 1'b0; trdy = 2'b11;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 0, 64'(tvalid), 64'd0);
    chk("rst_pulses", 0, 64'({dropped, ovfl}), 64'd0);
    rst_n = 1'b1;

    // 16-beat good frame, continuous ready
    clr();
    for (int i = 0; i < 16; i++) drive(0, 32'hA000_0000 + i, 4'hF, i == 15, 0);
    idle(25);
    chk("t1_beats", 0, 64'(obs_n[0]), 64'd16);
    chk("t1_first_data", 0, 64'(obs_e[0][0][31:0]), 64'hA000_0000);
    chk("t1_last_on_16", 0, 64'(obs_e[0][15][36]), 64'd1);
    chk("t1_no_last_15", 0, 64'(obs_e[0][14][36]), 64'd0);
    // last beat at edge N, tvalid up after N+2, first handshake at edge N+3
    chk("t1_latency", 0, 64'(obs_c[0][0] - lastc[0]), 64'd3);

    // Same frame with err on the last beat, then a good 4-beat frame
    clr();
    for (int i = 0; i < 16; i++) drive(0, 32'hB000_0000 + i, 4'hF, i == 15, i == 15);
    idle(10);
    chk("t2_no_beats", 0, 64'(obs_n[0]), 64'd0);
    chk("t2_drop_once", 0, 64'(drop_n[0]), 64'd1);
    for (int i = 0; i < 4; i++) drive(0, 32'hB100_0000 + i, 4'hF, i == 3, 0);
    idle(15);
    chk("t2_good_beats", 0, 64'(obs_n[0]), 64'd4);
    chk("t2_good_last", 0, 64'(obs_e[0][3]), 64'({1'b1, 4'hF, 32'hB100_0003}));

    // DEPTH=16 overflow with no ready, then an 8-beat frame
    clr();
    trdy[1] = 1'b0;
    for (int i = 0; i < 20; i++) drive(1, 32'hC000_0000 + i, 4'hF, i == 19, 0);
    idle(3);
    chk("t3_ovf_once", 1, 64'(ov_n[1]), 64'd1);
    chk("t3_ovf_beat", 1, 64'(ov_beat[1]), 64'd16);
    chk("t3_drop_once", 1, 64'(drop_n[1]), 64'd1);
    chk("t3_drop_after_last", 1, 64'(drop_c[1] - lastc[1]), 64'd1);
    for (int i = 0; i < 8; i++) drive(1, 32'hD000_0000 + i, 4'hF, i == 7, 0);
    idle(5);
    chk("t3_held", 1, 64'(obs_n[1]), 64'd0);
    trdy[1] = 1'b1;
    idle(20);
    chk("t3_beats", 1, 64'(obs_n[1]), 64'd8);
    chk("t3_first", 1, 64'(obs_e[1][0]), 64'({1'b0, 4'hF, 32'hD000_0000}));
    chk("t3_last", 1, 64'(obs_e[1][7]), 64'({1'b1, 4'hF, 32'hD000_0007}));

    // Three full beats then an empty last beat
    clr();
    for (int i = 0; i < 3; i++) drive(0, 32'h3300_0000 + i, 4'hF, 0, 0);
    drive(0, 32'h0, 4'h0, 1, 0);
    idle(12);
    chk("t4_beats", 0, 64'(obs_n[0]), 64'd3);
    chk("t4_b0", 0, 64'(obs_e[0][0]), 64'({1'b0, 4'hF, 32'h3300_0000}));
    chk("t4_b2", 0, 64'(obs_e[0][2]), 64'({1'b1, 4'hF, 32'h3300_0002}));

    // Back-to-back 5- and 7-beat frames with toggling ready
    clr();
    trdy[0] = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) drive(0, 32'hE000_0000 + i, (i == 4) ? 4'h3 : 4'hF, i == 4, 0);
        for (int i = 0; i < 7; i++) drive(0, 32'hF000_0000 + i, (i == 6) ? 4'h3 : 4'hF, i == 6, 0);
        idle(1);
      end
      begin
        repeat (60) begin
          @(negedge clk);
          trdy[0] = ~trdy[0];
        end
      end
    join
    trdy[0] = 1'b1;
    idle(10);
    chk("t5_beats", 0, 64'(obs_n[0]), 64'd12);
    chk("t5_f1_last", 0, 64'(obs_e[0][4]), 64'({1'b1, 4'h3, 32'hE000_0004}));
    chk("t5_f2_first", 0, 64'(obs_e[0][5]), 64'({1'b0, 4'hF, 32'hF000_0000}));
    chk("t5_f2_last", 0, 64'(obs_e[0][11]), 64'({1'b1, 4'h3, 32'hF000_0006}));

    // Reset asserted mid-frame while a committed frame is stalled at the output
    clr();
    trdy[0] = 1'b0;
    for (int i = 0; i < 2; i++) drive(0, 32'h5500_0000 + i, 4'hF, i == 1, 0);
    idle(6);
    chk("t6_stalled_valid", 0, 64'(tvalid[0]), 64'd1);
    for (int i = 0; i < 5; i++) drive(0, 32'h6600_0000 + i, 4'hF, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_reset_valid", 0, 64'(tvalid[0]), 64'd0);
    idle(3);
    rst_n = 1'b1;
    trdy[0] = 1'b1;
    clr();
    for (int i = 0; i < 4; i++) drive(0, 32'h7700_0000 + i, 4'hF, i == 3, 0);
    idle(15);
    chk("t6_beats", 0, 64'(obs_n[0]), 64'd4);
    chk("t6_first", 0, 64'(obs_e[0][0]), 64'({1'b0, 4'hF, 32'h7700_0000}));
    chk("t6_last", 0, 64'(obs_e[0][3]), 64'({1'b1, 4'hF, 32'h7700_0003}));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
